// File: rtl/rf_pkg.sv
// Shared defaults for the multi-port register file: default geometry and the
// address/data types sized for that default configuration.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_DEPTH    = 32;
  localparam int RF_NUM_RD   = 2;
  localparam int RF_NUM_WR   = 2;
  localparam int RF_ZERO_REG = 1;
  localparam int RF_ADDR_W   = $clog2(RF_DEPTH);

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: same-cycle write bypass (highest write port wins),
// register-0 masking and the bypass-aware busy indication.
module rf_read_port import rf_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              rd_sel,
  input  logic [DATA_W-1:0]              mem_data,
  input  logic                           busy_bit,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_sel,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_busy
);

  logic wr_hit;

  // Later ports overwrite earlier matches, giving the higher index priority.
  always_comb begin
    rd_data = mem_data;
    wr_hit  = 1'b0;
    if (!rst) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_sel[j] == rd_sel)) begin
          rd_data = wr_data[j];
          wr_hit  = 1'b1;
        end
      end
    end
    if ((ZERO_REG != 0) && (rd_sel == '0)) begin
      rd_data = '0;
    end
    rd_busy = !rst && busy_bit && !wr_hit;
  end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file for Decode: NUM_RD bypassing read ports, NUM_WR
// prioritised write ports, optional zero register and a busy scoreboard.
module rf_mp import rf_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int ZERO_REG = RF_ZERO_REG,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_sel,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_sel,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic                           rsv_en,
  input  logic [ADDR_W-1:0]              rsv_sel,
  input  logic                           flush,
  output logic [DEPTH-1:0]               busy,
  output logic                           wr_conflict
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr_conflict_q, wr_conflict_d;

  // Higher-index ports are applied last so they win a same-address collision.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        mem_d[wr_sel[j]] = wr_data[j];
      end
    end
    if (ZERO_REG != 0) begin
      mem_d[0] = '0;
    end
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_d[r] = '0;
      end
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int k = i + 1; k < NUM_WR; k++) begin
        if (wr_en[i] && wr_en[k] && (wr_sel[i] == wr_sel[k]) &&
            !((ZERO_REG != 0) && (wr_sel[i] == '0))) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
    if (rst) begin
      wr_conflict_d = 1'b0;
    end
  end

  // A reservation is applied after write clears: a new producer outranks retirement.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        busy_d[wr_sel[j]] = 1'b0;
      end
    end
    if (rsv_en) begin
      busy_d[rsv_sel] = 1'b1;
    end
    if (flush || rst) begin
      busy_d = '0;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q         <= mem_d;
    busy_q        <= busy_d;
    wr_conflict_q <= wr_conflict_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .rst      (rst),
      .rd_sel   (rd_sel[i]),
      .mem_data (mem_q[rd_sel[i]]),
      .busy_bit (busy_q[rd_sel[i]]),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .rd_data  (rd_data[i]),
      .rd_busy  (rd_busy[i])
    );
  end

  assign busy        = busy_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp (4 read, 2 write, 64 regs, zero register)
// against a per-register behavioural model of the register file.
module tb_rf_mp;

  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int AW = 6;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NRD-1:0][AW-1:0]   rd_sel;
  logic [NRD-1:0][DW-1:0]   rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_sel;
  logic [NWR-1:0][DW-1:0]   wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_sel;
  logic                     flush;
  logic [DEPTH-1:0]         busy;
  logic                     wr_conflict;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_busy [DEPTH];
  bit            ref_conflict;

  rf_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_sel(rsv_sel), .flush(flush), .busy(busy), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit written_now(input logic [AW-1:0] a);
    bit w = 0;
    for (int j = 0; j < NWR; j++) if (wr_en[j] && wr_sel[j] == a) w = 1;
    return w;
  endfunction

  // Expected combinational read: zero register, else last matching write, else storage.
  function automatic logic [DW-1:0] exp_rd_data(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = ref_mem[a];
    if (!rst) for (int j = 0; j < NWR; j++) if (wr_en[j] && wr_sel[j] == a) v = wr_data[j];
    return v;
  endfunction

  function automatic bit exp_rd_busy(input logic [AW-1:0] a);
    return !rst && ref_busy[a] && !written_now(a);
  endfunction

  function automatic logic [DEPTH-1:0] exp_busy_vec();
    logic [DEPTH-1:0] v;
    for (int r = 0; r < DEPTH; r++) v[r] = ref_busy[r];
    return v;
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        ref_mem[r] = '0;
        ref_busy[r] = 0;
      end
      ref_conflict = 0;
    end else begin
      ref_conflict = wr_en[0] && wr_en[1] && (wr_sel[0] == wr_sel[1]) && (wr_sel[0] != 0);
      for (int r = 1; r < DEPTH; r++) begin
        for (int j = 0; j < NWR; j++) if (wr_en[j] && wr_sel[j] == r) ref_mem[r] = wr_data[j];
        if (flush) ref_busy[r] = 0;
        else if (rsv_en && rsv_sel == r) ref_busy[r] = 1;
        else if (written_now(AW'(r))) ref_busy[r] = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; wr_en = '0; wr_sel = '0; wr_data = '0;
    rsv_en = 0; rsv_sel = '0; flush = 0; rd_sel = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    wr_en = 2'b01; wr_sel[0] = 5; wr_data[0] = 32'hDEADBEEF;
    rsv_en = 1; rsv_sel = 5;
    tick();
    rst = 1; wr_en = 2'b11; wr_sel[0] = 6; wr_sel[1] = 7; rsv_en = 1; rsv_sel = 8;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("[TB] FAIL reset_busy actual=%h required=0", busy);
    end
    checks++;
    if (wr_conflict !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_conflict actual=%b required=0", wr_conflict);
    end
    for (int a = 0; a < DEPTH; a++) begin
      for (int p = 0; p < NRD; p++) rd_sel[p] = AW'(a);
      #1;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rd_data[p] !== '0 || rd_busy[p] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL reset_read r%0d port%0d actual=%h/%b required=0/0", a, p, rd_data[p], rd_busy[p]);
        end
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr_en = 2'b01; wr_sel[0] = 7; wr_data[0] = 32'h12345678; rd_sel[0] = 7;
    #1;
    checks++;
    if (rd_data[0] !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle actual=%h required=12345678", rd_data[0]);
    end
    tick();
    wr_en = '0;
    #1;
    checks++;
    if (rd_data[0] !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL bypass_stored actual=%h required=12345678", rd_data[0]);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    wr_en = 2'b11; wr_sel[0] = 9; wr_sel[1] = 9;
    wr_data[0] = 32'hAAAA0000; wr_data[1] = 32'h5555FFFF; rd_sel[1] = 9;
    #1;
    checks++;
    if (rd_data[1] !== 32'h5555FFFF) begin
      errors++;
      $display("[TB] FAIL collision_bypass actual=%h required=5555ffff", rd_data[1]);
    end
    tick();
    wr_en = '0;
    #1;
    checks++;
    if (wr_conflict !== 1'b1 || rd_data[1] !== 32'h5555FFFF) begin
      errors++;
      $display("[TB] FAIL collision_r9 actual=%b/%h required=1/5555ffff", wr_conflict, rd_data[1]);
    end
    tick();
    checks++;
    if (wr_conflict !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collision_one_cycle actual=%b required=0", wr_conflict);
    end
    wr_en = 2'b11; wr_sel[0] = 0; wr_sel[1] = 0; rd_sel[1] = 0;
    tick();
    wr_en = '0;
    #1;
    checks++;
    if (wr_conflict !== 1'b0 || rd_data[1] !== '0) begin
      errors++;
      $display("[TB] FAIL collision_r0 actual=%b/%h required=0/0", wr_conflict, rd_data[1]);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    rsv_en = 1; rsv_sel = 12;
    tick();
    rsv_en = 0; rd_sel[2] = 12;
    #1;
    checks++;
    if (busy[12] !== 1'b1 || rd_busy[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_reserve actual=%b/%b required=1/1", busy[12], rd_busy[2]);
    end
    wr_en = 2'b10; wr_sel[1] = 12; wr_data[1] = 32'h0BADF00D;
    #1;
    checks++;
    if (rd_busy[2] !== 1'b0 || rd_data[2] !== 32'h0BADF00D) begin
      errors++;
      $display("[TB] FAIL sb_write_bypass actual=%b/%h required=0/0badf00d", rd_busy[2], rd_data[2]);
    end
    tick();
    wr_en = '0;
    #1;
    checks++;
    if (busy[12] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sb_cleared actual=%b required=0", busy[12]);
    end
    wr_en = 2'b01; wr_sel[0] = 12; rsv_en = 1; rsv_sel = 12;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy[12] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_rsv_beats_write actual=%b required=1", busy[12]);
    end
    rsv_en = 1; rsv_sel = 0;
    tick();
    rsv_en = 0;
    #1;
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sb_r0_reserve actual=%b required=0", busy[0]);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int r = 3; r <= 5; r++) begin
      rsv_en = 1; rsv_sel = AW'(r);
      tick();
    end
    rsv_en = 0;
    #1;
    checks++;
    if (busy[5:3] !== 3'b111) begin
      errors++;
      $display("[TB] FAIL flush_setup actual=%b required=111", busy[5:3]);
    end
    flush = 1; rsv_en = 1; rsv_sel = 6;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("[TB] FAIL flush_clear actual=%h required=0", busy);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e_data;
    bit            e_busy;
    for (int c = 0; c < 1000; c++) begin
      idle_inputs();
      rst   = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 4);
      for (int p = 0; p < NRD; p++)
        rd_sel[p] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
      for (int j = 0; j < NWR; j++) begin
        wr_en[j]   = ($urandom_range(0, 2) != 0);
        wr_sel[j]  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
        wr_data[j] = $urandom;
      end
      rsv_en  = ($urandom_range(0, 1) == 0);
      rsv_sel = AW'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < NRD; p++) begin
        e_data = exp_rd_data(rd_sel[p]);
        e_busy = exp_rd_busy(rd_sel[p]);
        checks++;
        if (rd_data[p] !== e_data || rd_busy[p] !== e_busy) begin
          errors++;
          $display("[TB] FAIL rand_read cyc%0d port%0d sel%0d actual=%h/%b required=%h/%b",
                   c, p, rd_sel[p], rd_data[p], rd_busy[p], e_data, e_busy);
        end
      end
      tick();
      checks++;
      if (busy !== exp_busy_vec() || wr_conflict !== ref_conflict) begin
        errors++;
        $display("[TB] FAIL rand_state cyc%0d actual=%h/%b required=%h/%b",
                 c, busy, wr_conflict, exp_busy_vec(), ref_conflict);
      end
    end
  endtask

  initial begin
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
